// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - Multi-port register file, 2 write / NRD read ports, with a sequenced full clear.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to matching read lanes.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 4,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    output logic                     busy_o,
    input  logic                     we_a_i,
    input  logic [ADDR_W-1:0]        waddr_a_i,
    input  logic [DATA_W-1:0]        wdata_a_i,
    input  logic                     we_b_i,
    input  logic [ADDR_W-1:0]        waddr_b_i,
    input  logic [DATA_W-1:0]        wdata_b_i,
    input  logic [NRD*ADDR_W-1:0]    raddr_i,
    output logic [NRD*DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  cnt;
    logic [ADDR_W-1:0]  cnt_nx;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               wr_idle;
    logic               clr_wr;
    logic               wen_a;
    logic               wen_b;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (clr_i) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                cnt_nx = cnt + ADDR_W'(1);
                if (cnt == LAST) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign busy_o  = (state == CLEAR);
    assign wr_idle = rst_i && (state == IDLE);
    assign clr_wr  = rst_i && (state == CLEAR);

    // Entry 0 never accepts data when it is the hardwired zero register.
    assign wen_a = wr_idle && we_a_i && !((ZERO_R0 != 0) && (waddr_a_i == '0));
    assign wen_b = wr_idle && we_b_i && !((ZERO_R0 != 0) && (waddr_b_i == '0));

    // Port B is written last so it wins an address collision.
    always_ff @(posedge clk_i) begin
        if (clr_wr) begin
            mem[cnt] <= '0;
        end else begin
            if (wen_a) begin
                mem[waddr_a_i] <= wdata_a_i;
            end
            if (wen_b) begin
                mem[waddr_b_i] <= wdata_b_i;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] fwd;
        logic              force_zero;

        assign ra     = raddr_i[k*ADDR_W +: ADDR_W];
        assign stored = mem[ra];

`ifdef REGFILE_BYPASS_EN
        assign fwd = (wen_b && (waddr_b_i == ra)) ? wdata_b_i :
                     (wen_a && (waddr_a_i == ra)) ? wdata_a_i : stored;
`else
        assign fwd = stored;
`endif

        assign force_zero = busy_o || ((ZERO_R0 != 0) && (ra == '0));
        assign rdata_o[k*DATA_W +: DATA_W] = force_zero ? '0 : fwd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - Scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    typedef struct {
        logic           busy;
        logic [NR*DW-1:0] rd;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              clr_i = 1'b0;
    logic              busy_o;
    logic              we_a_i = 1'b0;
    logic [AW-1:0]     waddr_a_i = '0;
    logic [DW-1:0]     wdata_a_i = '0;
    logic              we_b_i = 1'b0;
    logic [AW-1:0]     waddr_b_i = '0;
    logic [DW-1:0]     wdata_b_i = '0;
    logic [NR*AW-1:0]  raddr_i = '0;
    logic [NR*DW-1:0]  rdata_o;

    exp_t              sb_q[$];
    logic [DW-1:0]     model_mem [DEPTH];
    int                clear_left = 0;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;

    regfile_mp dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy_o),
        .we_a_i(we_a_i), .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i),
        .we_b_i(we_b_i), .waddr_b_i(waddr_b_i), .wdata_b_i(wdata_b_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [NR*AW-1:0] all_lanes(input logic [AW-1:0] a);
        return {NR{a}};
    endfunction

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Drive one cycle of inputs, queue the expected outputs for that cycle, then advance the model over the edge.
    task automatic step(input logic r, input logic c,
                        input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        input logic [NR*AW-1:0] ra);
        exp_t e;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        @(posedge clk_i);
        #1;
        rst_i = r; clr_i = c;
        we_a_i = wa; waddr_a_i = aa; wdata_a_i = da;
        we_b_i = wb; waddr_b_i = ab; wdata_b_i = db;
        raddr_i = ra;
        e.busy = (clear_left > 0);
        e.rd = '0;
        for (int k = 0; k < NR; k++) begin
            a = ra[k*AW +: AW];
            v = model_mem[a];
`ifdef REGFILE_BYPASS_EN
            if (r && wb && ab == a) v = db;
            else if (r && wa && aa == a) v = da;
`endif
            if (e.busy || a == 0) v = '0;
            e.rd[k*DW +: DW] = v;
        end
        sb_q.push_back(e);
        if (!r) begin
            clear_left = DEPTH;
            model_zero();
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (c) begin
            clear_left = DEPTH;
            model_zero();
        end else begin
            if (wa && aa != 0) model_mem[aa] = da;
            if (wb && ab != 0) model_mem[ab] = db;
        end
    endtask

    task automatic idle_read(input logic [NR*AW-1:0] ra);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (busy_o !== e.busy) begin
                bad++;
                $display("FAIL busy cycle %0d: got %0b want %0b", cyc, busy_o, e.busy);
            end
            for (int k = 0; k < NR; k++) begin
                total++;
                if (rdata_o[k*DW +: DW] !== e.rd[k*DW +: DW]) begin
                    bad++;
                    $display("FAIL rdata lane %0d cycle %0d: got %h want %h", k, cyc,
                             rdata_o[k*DW +: DW], e.rd[k*DW +: DW]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic wa, wb, c;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;
        logic [NR*AW-1:0] ra;

        // Two reset edges; after them the design is clearing with the full count ahead.
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        clear_left = DEPTH;
        model_zero();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++) idle_read(all_lanes(AW'(i)));
        for (int i = 0; i < DEPTH; i++) idle_read(all_lanes(AW'(i)));

        step(1'b1, 1'b0, 1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, all_lanes(5'd7));
        idle_read(all_lanes(5'd7));

        step(1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0, all_lanes(5'd0));
        idle_read(all_lanes(5'd0));

        step(1'b1, 1'b0, 1'b1, 5'd3, 32'hA5A5_0001, 1'b0, '0, '0, all_lanes(5'd3));
        idle_read(all_lanes(5'd3));

        // Reset ten cycles into a clear, with writes attempted throughout.
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, all_lanes(5'd7));
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b1, 5'd9, 32'h0BAD_0000 + i, 1'b0, '0, '0, all_lanes(5'd9));
        step(1'b0, 1'b0, 1'b1, 5'd9, 32'h0BAD_00FF, 1'b1, 5'd7, 32'h0BAD_00FE, all_lanes(5'd9));
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 1'b1, 5'd9, 32'h0BAD_1000 + i, 1'b1, 5'd7, 32'h0BAD_2000 + i,
                 {5'd9, 5'd7, 5'd3, 5'd1});
        idle_read({5'd9, 5'd7, 5'd3, 5'd1});

        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, all_lanes(AW'(i)));
        for (int i = 0; i < 30; i++) idle_read(all_lanes(AW'(i)));

        for (int i = 0; i < 400; i++) begin
            c  = ($urandom_range(0, 59) == 0);
            wa = $urandom_range(0, 1);
            wb = $urandom_range(0, 1);
            aa = AW'($urandom_range(0, DEPTH - 1));
            ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, DEPTH - 1));
            da = $urandom;
            db = $urandom;
            for (int k = 0; k < NR; k++)
                ra[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, DEPTH - 1));
            step(1'b1, c, wa, aa, da, wb, ab, db, ra);
        end
        idle_read('0);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk_i);
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
